// File: rtl/relu_share_sched_if.sv
// Bus bundle for relu_share_sched: neuron accumulator side, shared ReLU
// operand/result pair and the tagged activation output stream.
interface relu_share_sched_if #(
    parameter int NUM_REQ        = 10,
    parameter int dataWidth      = 16,
    parameter int IntWidthExtend = 10
);
    localparam int ACC_W = 2 * dataWidth + IntWidthExtend;
    localparam int IDX_W = $clog2(NUM_REQ);

    logic                       start;
    logic [NUM_REQ-1:0]         acc_valid;
    logic [NUM_REQ*ACC_W-1:0]   acc_data;
    logic [NUM_REQ-1:0]         acc_ready;
    logic [ACC_W-1:0]           relu_x;
    logic [dataWidth-1:0]       relu_out;
    logic                       out_valid;
    logic [dataWidth-1:0]       out_data;
    logic [IDX_W-1:0]           out_idx;
    logic                       out_ready;
    logic                       busy;
    logic                       layer_done;

    // Environment side: neurons, the ReLU stage and the downstream consumer.
    modport master (
        output start, acc_valid, acc_data, relu_out, out_ready,
        input  acc_ready, relu_x, out_valid, out_data, out_idx, busy, layer_done
    );

    // Scheduler side.
    modport slave (
        input  start, acc_valid, acc_data, relu_out, out_ready,
        output acc_ready, relu_x, out_valid, out_data, out_idx, busy, layer_done
    );
endinterface

// File: rtl/relu_share_sched.sv
// Round-robin scheduler sharing one ReLU/saturation stage between NUM_REQ
// neuron accumulators. Results are serialised into the ReLU, collected in a
// small FIFO and streamed out tagged with their neuron index.
module relu_share_sched #(
    parameter int NUM_REQ        = 10,
    parameter int dataWidth      = 16,
    parameter int IntWidthExtend = 10,
    parameter int OUT_DEPTH      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    relu_share_sched_if.slave   bus
);
    localparam int ACC_W = 2 * dataWidth + IntWidthExtend;
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [NUM_REQ-1:0]     r_served;
    logic [IDX_W-1:0]       r_rr;
    logic [IDX_W-1:0]       r_tag;
    logic                   r_inflight;
    logic [ACC_W-1:0]       r_relu_x;
    logic [dataWidth-1:0]   r_fifo_data [OUT_DEPTH];
    logic [IDX_W-1:0]       r_fifo_idx  [OUT_DEPTH];
    logic [PTR_W-1:0]       r_wptr, r_rptr;
    logic [CNT_W-1:0]       r_count;

    logic [NUM_REQ-1:0]     w_eligible;
    logic [NUM_REQ-1:0]     w_gnt_vec;
    logic [NUM_REQ-1:0]     w_served_nxt;
    logic [IDX_W-1:0]       w_sel;
    logic                   w_found;
    logic                   w_credit;
    logic                   w_grant;
    logic                   w_push;
    logic                   w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_eligible = bus.acc_valid & ~r_served;
    assign w_pop      = (r_count != '0) & bus.out_ready;
    assign w_push     = r_inflight;
    // Credit counts queued plus in-flight results, net of this cycle's pop,
    // so a grant never lands a result in a full FIFO.
    assign w_credit   = (r_count + CNT_W'(r_inflight) - CNT_W'(w_pop)) < CNT_W'(OUT_DEPTH);

    // First eligible neuron searching upward from the rr pointer, with wrap.
    always_comb begin : arb
        int j;
        w_found = 1'b0;
        w_sel   = '0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_rr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!w_found && w_eligible[j]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(j);
            end
        end
    end

    assign w_grant      = (r_state == S_RUN) && w_found && w_credit;
    assign w_gnt_vec    = w_grant ? (NUM_REQ'(1) << w_sel) : '0;
    assign w_served_nxt = r_served | w_gnt_vec;

    // Next state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (&w_served_nxt) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!r_inflight && (r_count == '0)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.acc_ready  = w_gnt_vec;
    assign bus.busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.layer_done = (r_state == S_DONE);
    assign bus.relu_x     = r_relu_x;
    assign bus.out_valid  = (r_count != '0);
    assign bus.out_data   = r_fifo_data[r_rptr];
    assign bus.out_idx    = r_fifo_idx[r_rptr];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Served mask, rr pointer and ReLU issue register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_served   <= '0;
            r_rr       <= '0;
            r_tag      <= '0;
            r_inflight <= 1'b0;
            r_relu_x   <= '0;
        end else begin
            r_inflight <= w_grant;
            if ((r_state == S_IDLE) && bus.start) begin
                r_served <= '0;
                r_rr     <= '0;
            end else if (w_grant) begin
                r_served <= w_served_nxt;
                r_rr     <= (w_sel == IDX_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
                r_tag    <= w_sel;
                r_relu_x <= bus.acc_data[int'(w_sel)*ACC_W +: ACC_W];
            end
        end
    end

    // Output FIFO: the ReLU result of last cycle's issue is pushed with its tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_idx[i]  <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wptr] <= bus.relu_out;
                r_fifo_idx[r_wptr]  <= r_tag;
                r_wptr              <= ptr_inc(r_wptr);
            end
            if (w_pop) r_rptr <= ptr_inc(r_rptr);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end
endmodule

// File: tb/tb_relu_share_sched.sv
// Scoreboard bench for relu_share_sched: expected grants and tagged outputs
// are queued as stimulus is driven and compared as the DUT produces them.
`timescale 1ns/1ps
module tb_relu_share_sched;
    localparam int NR    = 10;
    localparam int DW    = 16;
    localparam int ACC_W = 42;
    localparam int IW    = 4;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    relu_share_sched_if #(.NUM_REQ(NR), .dataWidth(DW), .IntWidthExtend(10)) ifc();

    relu_share_sched #(.NUM_REQ(NR), .dataWidth(DW), .IntWidthExtend(10), .OUT_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    // ReLU model: drop 8 fraction bits, clip negatives to 0, saturate at max.
    function automatic logic [DW-1:0] relu_f(input logic [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] s;
        s = $signed(x) >>> 8;
        if (s < 0) return '0;
        if (s > 42'sd32767) return 16'h7fff;
        return s[DW-1:0];
    endfunction

    assign ifc.relu_out = relu_f(ifc.relu_x);

    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, n_grant = 0, n_out = 0, n_done = 0;
    int   last_gcyc = 0, last_hs = 0, done_cyc = 0;
    bit   chk_lat = 0;
    int   eg_q[$];
    exp_t eo_q[$];
    int   gcyc_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input int i, input logic [DW-1:0] d);
        eg_q.push_back(i);
        eo_q.push_back('{idx: IW'(i), data: d});
    endtask

    task automatic set_acc(input int i, input logic [ACC_W-1:0] v);
        ifc.acc_data[i*ACC_W +: ACC_W] = v;
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc && !ifc.layer_done; i++) @(negedge clk);
        chk("done_seen", ifc.layer_done, 1);
        tick();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ardy"}, ifc.acc_ready, 0);
        chk({tag, "_rx"},   ifc.relu_x, 0);
        chk({tag, "_ov"},   ifc.out_valid, 0);
        chk({tag, "_od"},   ifc.out_data, 0);
        chk({tag, "_oi"},   ifc.out_idx, 0);
        chk({tag, "_busy"}, ifc.busy, 0);
        chk({tag, "_done"}, ifc.layer_done, 0);
    endtask

    // Monitor: grants and output handshakes against the scoreboard queues.
    always @(negedge clk) begin
        int   gi;
        int   g;
        exp_t e;
        cyc++;
        if (rst_n) begin
            if (ifc.acc_ready != '0) begin
                gi = 0;
                for (int b = 0; b < NR; b++) if (ifc.acc_ready[b]) gi = b;
                n_grant++;
                chk("grant_onehot", $countones(ifc.acc_ready), 1);
                if (eg_q.size() == 0) chk("grant_extra", ifc.acc_ready, 0);
                else chk("grant_idx", gi, eg_q.pop_front());
                if (chk_lat && gi != 0) chk("grant_consec", cyc - last_gcyc, 1);
                last_gcyc = cyc;
                gcyc_q.push_back(cyc);
            end
            if (ifc.out_valid && ifc.out_ready) begin
                n_out++;
                last_hs = cyc;
                if (eo_q.size() == 0) chk("out_extra", ifc.out_valid, 0);
                else begin
                    e = eo_q.pop_front();
                    chk("out_idx", ifc.out_idx, e.idx);
                    chk("out_data", ifc.out_data, e.data);
                end
                if (gcyc_q.size() != 0) begin
                    g = gcyc_q.pop_front();
                    if (chk_lat) chk("grant_to_out", cyc - g, 2);
                end
            end
            if (ifc.layer_done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, base2;
        int order[NR] = '{4, 7, 8, 3, 5, 6, 9, 0, 1, 2};
        logic [ACC_W-1:0] v;
        logic [DW-1:0] d0;

        ifc.start = 0; ifc.acc_valid = '0; ifc.acc_data = '0; ifc.out_ready = 1;
        repeat (3) tick();
        chk_quiet("reset");
        rst_n = 1;
        tick();

        // Full pass: all valid, data i<<18 -> relu i*1024, back-to-back.
        for (int i = 0; i < NR; i++) begin
            set_acc(i, ACC_W'(i) << 18);
            exp_push(i, DW'(i * 1024));
        end
        ifc.acc_valid = '1;
        chk_lat = 1;
        base = n_done;
        ifc.start = 1'b1;
        @(negedge clk);
        chk("t1_idle_busy", ifc.busy, 0);
        tick();
        ifc.start = 1'b0;
        @(negedge clk);
        chk("t1_first_grant", ifc.acc_ready, 1);
        chk("t1_busy", ifc.busy, 1);
        wait_done(200);
        chk("t1_done_lag", done_cyc - last_hs, 2);
        repeat (3) tick();
        chk("t1_done_once", n_done - base, 1);
        chk("t1_left", eo_q.size(), 0);
        chk_lat = 0;

        // Backpressure: out_ready=0 allows exactly two grants.
        for (int i = 0; i < NR; i++) begin
            v = (i == 5) ? 42'h3_0000_0000 : ACC_W'($urandom_range(0, 24'hFFFFFF));
            set_acc(i, v);
            exp_push(i, relu_f(v));
            if (i == 0) d0 = relu_f(v);
        end
        ifc.out_ready = 0;
        base = n_grant;
        pulse_start();
        repeat (6) tick();
        chk("t2_grants", n_grant - base, 2);
        chk("t2_stall", ifc.acc_ready, 0);
        chk("t2_ov", ifc.out_valid, 1);
        chk("t2_head_idx", ifc.out_idx, 0);
        chk("t2_head_data", ifc.out_data, d0);
        ifc.out_ready = 1;
        wait_done(200);
        chk("t2_left", eo_q.size(), 0);

        // Staggered valids, wrap search, ignored start, no re-grant.
        ifc.acc_valid = '0;
        for (int i = 0; i < NR; i++) set_acc(i, ACC_W'(i + 1) << 12);
        for (int i = 0; i < NR; i++) exp_push(order[i], relu_f(ACC_W'(order[i] + 1) << 12));
        ifc.acc_valid[4] = 1;
        pulse_start();
        repeat (3) tick();
        ifc.acc_valid[7] = 1;
        repeat (3) tick();
        pulse_start();
        chk("t3_busy_start", ifc.busy, 1);
        ifc.acc_valid[3] = 1;
        ifc.acc_valid[8] = 1;
        repeat (4) tick();
        ifc.acc_valid = '0;
        tick();
        ifc.acc_valid[7] = 1;
        repeat (3) tick();
        chk("t3_no_regrant", ifc.acc_ready, 0);
        ifc.acc_valid = '1;
        wait_done(200);
        chk("t3_grants_left", eg_q.size(), 0);
        chk("t3_left", eo_q.size(), 0);

        // Start with nothing valid: stays in RUN.
        ifc.acc_valid = '0;
        base = n_done;
        pulse_start();
        repeat (20) tick();
        chk("t4_busy", ifc.busy, 1);
        chk("t4_no_done", n_done - base, 0);

        // Reset mid-pass with one in flight and one queued.
        ifc.out_ready = 0;
        eg_q.push_back(0);
        eg_q.push_back(1);
        ifc.acc_valid = '1;
        tick();
        tick();
        chk("t5_pre_ov", ifc.out_valid, 1);
        rst_n = 0;
        #1;
        chk_quiet("t5_rst");
        ifc.acc_valid = '0;
        eg_q.delete();
        eo_q.delete();
        gcyc_q.delete();
        tick();
        rst_n = 1;
        ifc.out_ready = 1;
        base2 = n_out;
        repeat (10) tick();
        chk("t5_no_out", n_out - base2, 0);
        chk("t5_ov", ifc.out_valid, 0);

        // Clean pass after reset; odd neurons negative -> 0 with correct tag.
        for (int i = 0; i < NR; i++) begin
            v = ACC_W'(i) << 18;
            if (i % 2 == 1) v = -v;
            set_acc(i, v);
            exp_push(i, (i % 2 == 1) ? 16'd0 : DW'(i * 1024));
        end
        ifc.acc_valid = '1;
        chk_lat = 1;
        base = n_done;
        base2 = n_out;
        pulse_start();
        wait_done(200);
        chk("t6_done_lag", done_cyc - last_hs, 2);
        chk("t6_outs", n_out - base2, NR);
        chk("t6_done_once", n_done - base, 1);
        chk("t6_left", eo_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/relu_share_sched.md
Name: relu_share_sched

Overview:
Round-robin scheduler that shares one ReLU/saturation stage between NUM_REQ neuron accumulators of a layer (e.g. the 10 output neurons of MNIST_126_126_10).
- Each neuron raises a wide accumulator result once per layer pass.
- The block serialises these results into the shared ReLU (fixed 1-cycle registered latency, driven on relu_x) and collects the clipped results into an OUT_DEPTH FIFO.
- The FIFO results stream out tagged with their neuron index.
- layer_done is signalled once every neuron has been processed and the FIFO has drained.

Parameters:
NUM_REQ, 10, number of sharing neurons (≥2)
dataWidth, 16, activation width
IntWidthExtend, 10, accumulator guard bits; ACC_W = 2*dataWidth+IntWidthExtend (42)
OUT_DEPTH, 2, output FIFO depth (≥2)
IDX_W, $clog2(NUM_REQ), index width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a layer pass; honoured only in IDLE
acc_valid  in  NUM_REQ  neuron i has a result
acc_data  in  NUM_REQ*ACC_W  flattened results, neuron i at [i*ACC_W +: ACC_W]
acc_ready  out  NUM_REQ  one-hot grant pulse; result consumed
relu_x  out  ACC_W  operand to shared ReLU (registered)
relu_out  in  dataWidth  ReLU result, valid 1 cycle after relu_x issue
out_valid  out  1  FIFO head valid
out_data  out  dataWidth  activation
out_idx  out  IDX_W  neuron index of out_data
out_ready  in  1  downstream accept
busy  out  1  high in RUN/DRAIN
layer_done  out  1  1-cycle pulse at end of pass

Behaviour:
- Reset (async assert, sync release): state=IDLE. acc_ready=0, relu_x=0, out_valid=0, out_data=0, out_idx=0, busy=0, layer_done=0. FIFO empty, served mask=0, rr pointer=0, in-flight flags cleared.
- Reset mid-pass discards all in-flight and queued results. Nothing is emitted after release.

States:
- IDLE: start → RUN. Served mask is cleared and rr pointer is set to 0.
- RUN: each cycle, eligible = acc_valid & ~served. Grant the first eligible index searching from rr pointer upward, with wrap.
  - A grant requires credit: FIFO occupancy + in-flight count < OUT_DEPTH.
  - On grant to i: acc_ready[i]=1 that cycle, relu_x <= acc_data[i] at the edge, served[i] set, rr <= (i+1) mod NUM_REQ, in-flight tag <= i.
  - When served becomes all-ones → DRAIN.
- DRAIN: no grants. When in-flight=0 and FIFO empty → DONE.
- DONE: layer_done=1 for one cycle, then → IDLE.

Timing and data path:
- acc_ready is combinational from state, eligible, credit and rr.
- At most one grant per cycle; sustained 1 grant/cycle when out_ready=1.
- Issue at edge E (grant cycle ends). relu_out is sampled at edge E+1 and pushed to the FIFO with its tag. It is visible on out_valid/out_data/out_idx at the earliest in the cycle after E+1, so grant-to-out_valid = 2 cycles.
- A FIFO pop occurs when out_valid & out_ready. Simultaneous push and pop is allowed when full. The credit check counts the pop of the same cycle.
- relu_x holds its last value when idle. No arithmetic is done here; saturation and clipping belong to the ReLU.

Boundary cases:
- acc_valid from an already-served neuron: ignored, no grant.
- start outside IDLE: ignored.
- start with acc_valid=0: stay in RUN indefinitely.
- acc_valid dropping before grant: legal, no grant.
- out_ready=0 with full FIFO: grants stall and acc_valid must hold.
- NUM_REQ pointer wraps from NUM_REQ-1 to 0.

busy = RUN or DRAIN.

Test Plan:
- Reset, then start with all 10 acc_valid, out_ready=1, acc_data[i]=i<<18: grants 0..9 on consecutive cycles, with the first grant the cycle after start. out_idx 0..9 appears on consecutive cycles with a 2-cycle lag. layer_done pulses once, 2 cycles after the last out_valid handshake completes DRAIN. Model the ReLU in the bench.
- out_ready=0, all valid: exactly 2 grants (idx 0,1), then acc_ready stays 0. Raising out_ready resumes at idx 2 with no lost or duplicate outputs.
- Staggered valids 7, then 3, then 8 while rr=4: grant order 7, 8, 3 (search from pointer with wrap). A re-asserted acc_valid[7] is never re-granted.
- start pulsed during RUN: no effect, served mask kept. start with no valids: busy stays 1, layer_done stays 0.
- rst_n low for 1 cycle mid-pass with 1 in flight and 1 in FIFO: all outputs 0 immediately, no out_valid afterward. A new start gives a clean 10-result pass.
- Negative acc_data (MSB set) through the bench ReLU model: out_data=0 with correct out_idx tag.
